seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_ctrl_prescaler.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [3:0]  SEL_OFF    = 4'hF;
    localparam int unsigned SLOT_TICKS = 16;
    localparam int unsigned SLOT_W     = 4;

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        LIT   = 2'd1,
        DARK  = 2'd2
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode select with only the addressed digit pulled low.
    function automatic logic [3:0] one_cold(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Divides clk down to a one-cycle scan tick every PRESCALE cycles.
module scan_prescaler #(
    parameter int unsigned PRESCALE = 1563
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned      CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed LED scanner with a blanking guard tick per slot
// and per-slot brightness (lit tick count) control.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 1563
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] digit3,
    input  logic [7:0] digit2,
    input  logic [7:0] digit1,
    input  logic [7:0] digit0,
    input  logic [3:0] digit_en,
    input  logic [3:0] brightness,
    output logic [3:0] LEDSEL,
    output logic [7:0] LEDOUT,
    output logic [1:0] scan_idx,
    output logic       frame_start
);

    logic              tick;
    scan_state_t       state;
    logic [SLOT_W-1:0] slot_cnt;
    logic              running;
    logic [7:0]        pat_lat;
    logic              en_lat;
    logic [3:0]        bright_lat;

    digit_idx_t        next_idx;
    logic [7:0]        next_pat;
    logic              slot_end;

    scan_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Digit for the upcoming slot; the first tick after reset always opens digit 0.
    always_comb begin
        next_idx = running ? digit_idx_t'(scan_idx + 2'd1) : digit_idx_t'(0);
        next_pat = digit0;
        case (next_idx)
            2'd0:    next_pat = digit0;
            2'd1:    next_pat = digit1;
            2'd2:    next_pat = digit2;
            default: next_pat = digit3;
        endcase
        slot_end = !running || (slot_cnt == SLOT_W'(SLOT_TICKS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= GUARD;
            slot_cnt    <= '0;
            scan_idx    <= '0;
            running     <= 1'b0;
            pat_lat     <= '0;
            en_lat      <= 1'b0;
            bright_lat  <= '0;
            LEDSEL      <= SEL_OFF;
            LEDOUT      <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                if (slot_end) begin
                    // New slot: blank, snapshot this digit's inputs for the whole slot.
                    running     <= 1'b1;
                    state       <= GUARD;
                    slot_cnt    <= '0;
                    scan_idx    <= next_idx;
                    pat_lat     <= next_pat;
                    en_lat      <= digit_en[next_idx];
                    bright_lat  <= brightness;
                    LEDSEL      <= SEL_OFF;
                    LEDOUT      <= SEG_BLANK;
                    frame_start <= (next_idx == digit_idx_t'(0));
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                    unique case (state)
                        GUARD: begin
                            if ((bright_lat != 4'd0) && en_lat) begin
                                state  <= LIT;
                                LEDSEL <= one_cold(scan_idx);
                                LEDOUT <= pat_lat;
                            end else begin
                                state <= DARK;
                            end
                        end
                        LIT: begin
                            // Lit ticks occupy slot_cnt 1..bright_lat.
                            if (slot_cnt == bright_lat) begin
                                state  <= DARK;
                                LEDSEL <= SEL_OFF;
                                LEDOUT <= SEG_BLANK;
                            end
                        end
                        DARK: begin
                            state <= DARK;
                        end
                        default: begin
                            state  <= DARK;
                            LEDSEL <= SEL_OFF;
                            LEDOUT <= SEG_BLANK;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl using a PRESCALE=4 and a PRESCALE=1 instance.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst4, rst1;
    logic [7:0] d3, d2, d1, d0;
    logic [3:0] en, bright;
    logic [3:0] sel4, sel1;
    logic [7:0] out4, out1;
    logic [1:0] idx4, idx1;
    logic       fs4, fs1;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst4),
        .digit3(d3), .digit2(d2), .digit1(d1), .digit0(d0),
        .digit_en(en), .brightness(bright),
        .LEDSEL(sel4), .LEDOUT(out4), .scan_idx(idx4), .frame_start(fs4)
    );

    seg_scan_ctrl #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst1),
        .digit3(d3), .digit2(d2), .digit1(d1), .digit0(d0),
        .digit_en(en), .brightness(bright),
        .LEDSEL(sel1), .LEDOUT(out1), .scan_idx(idx1), .frame_start(fs1)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    int lit [4];
    int fs_cnt, fs_first, fs_second, bad_sel, blank_err, direct_sw;
    logic [3:0] prev_sel;

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) lit[i] = 0;
        fs_cnt = 0; fs_first = 0; fs_second = 0;
        bad_sel = 0; blank_err = 0; direct_sw = 0;
        prev_sel = 4'hF;
    endtask

    // Advance one clk, sample at the falling edge and accumulate frame statistics.
    task automatic sample(input bit use1);
        logic [3:0] s;
        logic [7:0] o;
        logic       f;
        @(negedge clk);
        cyc++;
        s = use1 ? sel1 : sel4;
        o = use1 ? out1 : out4;
        f = use1 ? fs1  : fs4;
        case (s)
            4'hE:    lit[0]++;
            4'hD:    lit[1]++;
            4'hB:    lit[2]++;
            4'h7:    lit[3]++;
            4'hF:    if (o !== 8'hFF) blank_err++;
            default: bad_sel++;
        endcase
        if (prev_sel != 4'hF && s != 4'hF && s != prev_sel) direct_sw++;
        prev_sel = s;
        if (f === 1'b1) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_first = cyc;
            else if (fs_cnt == 2) fs_second = cyc;
        end
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        repeat (2) @(negedge clk);
        rst4 = 1'b0;
        cyc = 0;
        clear_stats();
    endtask

    task automatic set_inputs(input logic [3:0] e, input logic [3:0] b);
        d0 = 8'hC0; d1 = 8'hF9; d2 = 8'hA4; d3 = 8'hB0;
        en = e; bright = b;
    endtask

    task automatic test_reset();
        set_inputs(4'hF, 4'hF);
        rst4 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL reset_ledsel got %h exp f", sel4); end
        checks++; if (out4 !== 8'hFF) begin errors++; $display("FAIL reset_ledout got %h exp ff", out4); end
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx4); end
        checks++; if (fs4 !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", fs4); end
    endtask

    task automatic check_lit(input string name, input int e0, input int e1, input int e2, input int e3);
        int exp_l [4];
        exp_l[0] = e0; exp_l[1] = e1; exp_l[2] = e2; exp_l[3] = e3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lit[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL %s_lit%0d got %0d exp %0d", name, i, lit[i], exp_l[i]);
            end
        end
        checks++; if (bad_sel !== 0) begin errors++; $display("FAIL %s_bad_sel got %0d exp 0", name, bad_sel); end
        checks++; if (blank_err !== 0) begin errors++; $display("FAIL %s_blank got %0d exp 0", name, blank_err); end
        checks++; if (direct_sw !== 0) begin errors++; $display("FAIL %s_no_guard got %0d exp 0", name, direct_sw); end
    endtask

    task automatic test_scan();
        set_inputs(4'hF, 4'hF);
        reset4();
        for (int k = 0; k < 264; k++) begin
            sample(1'b0);
            if (cyc == 4) begin
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL scan_c4_sel got %h exp f", sel4); end
            end
            if (cyc == 5) begin
                checks++; if (fs4 !== 1'b1) begin errors++; $display("FAIL scan_c5_fs got %b exp 1", fs4); end
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL scan_c5_sel got %h exp f", sel4); end
            end
            if (cyc == 6) begin
                checks++; if (fs4 !== 1'b0) begin errors++; $display("FAIL scan_c6_fs got %b exp 0", fs4); end
            end
            if (cyc == 8) begin
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL scan_c8_sel got %h exp f", sel4); end
            end
            if (cyc == 9) begin
                checks++; if (sel4 !== 4'hE) begin errors++; $display("FAIL scan_c9_sel got %h exp e", sel4); end
                checks++; if (out4 !== 8'hC0) begin errors++; $display("FAIL scan_c9_out got %h exp c0", out4); end
                checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL scan_c9_idx got %0d exp 0", idx4); end
            end
            if (cyc == 68) begin
                checks++; if (sel4 !== 4'hE) begin errors++; $display("FAIL scan_c68_sel got %h exp e", sel4); end
            end
            if (cyc == 69) begin
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL scan_c69_sel got %h exp f", sel4); end
                checks++; if (idx4 !== 2'd1) begin errors++; $display("FAIL scan_c69_idx got %0d exp 1", idx4); end
            end
            if (cyc == 73) begin
                checks++; if (sel4 !== 4'hD) begin errors++; $display("FAIL scan_c73_sel got %h exp d", sel4); end
                checks++; if (out4 !== 8'hF9) begin errors++; $display("FAIL scan_c73_out got %h exp f9", out4); end
            end
            if (cyc == 201) begin
                checks++; if (sel4 !== 4'h7) begin errors++; $display("FAIL scan_c201_sel got %h exp 7", sel4); end
                checks++; if (out4 !== 8'hB0) begin errors++; $display("FAIL scan_c201_out got %h exp b0", out4); end
                checks++; if (idx4 !== 2'd3) begin errors++; $display("FAIL scan_c201_idx got %0d exp 3", idx4); end
            end
        end
        check_lit("scan", 60, 60, 60, 60);
        checks++; if (fs_first !== 5) begin errors++; $display("FAIL scan_fs_first got %0d exp 5", fs_first); end
        checks++; if (fs_second !== 261) begin errors++; $display("FAIL scan_fs_second got %0d exp 261", fs_second); end
        checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL scan_fs_cnt got %0d exp 2", fs_cnt); end
    endtask

    task automatic test_brightness();
        set_inputs(4'hF, 4'd3);
        reset4();
        for (int k = 0; k < 264; k++) begin
            sample(1'b0);
            if (cyc == 20) begin
                checks++; if (sel4 !== 4'hE) begin errors++; $display("FAIL bright_c20_sel got %h exp e", sel4); end
            end
            if (cyc == 21) begin
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL bright_c21_sel got %h exp f", sel4); end
            end
        end
        check_lit("bright", 12, 12, 12, 12);
    endtask

    task automatic test_enable();
        set_inputs(4'b0101, 4'hF);
        reset4();
        for (int k = 0; k < 264; k++) sample(1'b0);
        check_lit("enable", 60, 0, 60, 0);
        checks++;
        if (fs_second - fs_first !== 256) begin
            errors++; $display("FAIL enable_frame got %0d exp 256", fs_second - fs_first);
        end
    endtask

    task automatic test_mid_change();
        set_inputs(4'hF, 4'hF);
        reset4();
        for (int k = 0; k < 264; k++) begin
            sample(1'b0);
            if (cyc == 90) begin
                bright = 4'd2;
                d1 = 8'h00;
            end
            if (cyc == 100) begin
                checks++; if (out4 !== 8'hF9) begin errors++; $display("FAIL mid_c100_out got %h exp f9", out4); end
            end
            if (cyc == 132) begin
                checks++; if (sel4 !== 4'hD) begin errors++; $display("FAIL mid_c132_sel got %h exp d", sel4); end
            end
            if (cyc == 144) begin
                checks++; if (sel4 !== 4'hB) begin errors++; $display("FAIL mid_c144_sel got %h exp b", sel4); end
            end
            if (cyc == 145) begin
                checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL mid_c145_sel got %h exp f", sel4); end
            end
        end
        check_lit("mid", 60, 60, 8, 8);
    endtask

    task automatic test_async_reset();
        set_inputs(4'hF, 4'hF);
        reset4();
        for (int k = 0; k < 162; k++) sample(1'b0);
        checks++; if (sel4 !== 4'hB) begin errors++; $display("FAIL areset_pre_sel got %h exp b", sel4); end
        checks++; if (idx4 !== 2'd2) begin errors++; $display("FAIL areset_pre_idx got %0d exp 2", idx4); end
        #2;
        rst4 = 1'b1;
        #1;
        checks++; if (sel4 !== 4'hF) begin errors++; $display("FAIL areset_sel got %h exp f", sel4); end
        checks++; if (out4 !== 8'hFF) begin errors++; $display("FAIL areset_out got %h exp ff", out4); end
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL areset_idx got %0d exp 0", idx4); end
        @(negedge clk);
        rst4 = 1'b0;
        cyc = 0;
        clear_stats();
        for (int k = 0; k < 6; k++) begin
            sample(1'b0);
            if (cyc == 4) begin
                checks++; if (fs4 !== 1'b0) begin errors++; $display("FAIL areset_c4_fs got %b exp 0", fs4); end
            end
            if (cyc == 5) begin
                checks++; if (fs4 !== 1'b1) begin errors++; $display("FAIL areset_c5_fs got %b exp 1", fs4); end
                checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL areset_c5_idx got %0d exp 0", idx4); end
            end
        end
    endtask

    task automatic test_prescale1();
        rst4 = 1'b1;
        set_inputs(4'hF, 4'd0);
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        cyc = 0;
        clear_stats();
        for (int k = 0; k < 140; k++) sample(1'b1);
        check_lit("p1", 0, 0, 0, 0);
        checks++; if (fs_first !== 2) begin errors++; $display("FAIL p1_fs_first got %0d exp 2", fs_first); end
        checks++; if (fs_second !== 66) begin errors++; $display("FAIL p1_fs_second got %0d exp 66", fs_second); end
        checks++; if (fs_cnt !== 3) begin errors++; $display("FAIL p1_fs_cnt got %0d exp 3", fs_cnt); end
    endtask

    initial begin
        rst4 = 1'b1;
        rst1 = 1'b1;
        set_inputs(4'hF, 4'hF);
        clear_stats();
        cyc = 0;
        test_reset();
        test_scan();
        test_brightness();
        test_enable();
        test_mid_change();
        test_async_reset();
        test_prescale1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
